jtcontra_gfx_romfetch: RTL and testbench

- Shared SDRAM fetch stage directly upstream of the two tile/sprite engines in the video section.
- Accepts the gfx1 and gfx2 ROM requests (cs, 18-bit address) and serves both from one SDRAM read port.
- Keeps a one-entry hold buffer per client, so a repeated address returns data with zero added latency.
- Arbitrates misses round-robin and flushes both buffers whenever the video bank changes.

---
 rtl/jtcontra_gfx_romfetch_pkg.sv | 21 ++
 rtl/jtcontra_gfx_romfetch_if.sv | 13 +
 rtl/jtcontra_gfx_romfetch_slot.sv | 51 +++++
 rtl/jtcontra_gfx_romfetch.sv | 162 ++++++++++++++++
 tb/tb_jtcontra_gfx_romfetch.sv | 267 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/jtcontra_gfx_romfetch_pkg.sv
// Shared types and constants for the gfx ROM fetch stage: FSM states,
// client indices, default SDRAM region bases and a saturating counter helper.
package jtcontra_romfetch_pkg;

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    WAIT
  } state_t;

  localparam logic GFX1 = 1'b0;
  localparam logic GFX2 = 1'b1;

  localparam logic [21:0] GFX1_OFFSET_DEF = 22'h00_0000;
  localparam logic [21:0] GFX2_OFFSET_DEF = 22'h04_0000;

  function automatic logic [15:0] sat_inc(input logic [15:0] v, input logic en);
    return (en && v != 16'hFFFF) ? v + 16'd1 : v;
  endfunction

endpackage

// File: rtl/jtcontra_gfx_romfetch_if.sv
// SDRAM read port shared by both gfx clients: request/address out, ack/ready/data back.
interface jtcontra_gfx_romfetch_if #(
  parameter int unsigned SW = 22
);
  logic          req;
  logic [SW-1:0] addr;
  logic          ack;
  logic          rdy;
  logic [15:0]   dout;

  modport master (output req, output addr, input ack, input rdy, input dout);
  modport slave  (input req, input addr, output ack, output rdy, output dout);
endinterface

// File: rtl/jtcontra_gfx_romfetch_slot.sv
// One-entry hold buffer for a single gfx client: tag, data and valid bit
// with a zero-latency hit compare against the client's current address.
module jtcontra_romfetch_slot #(
  parameter int unsigned AW = 18
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clr,
  input  logic          cs,
  input  logic [AW-1:0] addr,
  input  logic          wr,
  input  logic          wr_valid,
  input  logic [AW-1:0] wr_tag,
  input  logic [15:0]   wr_data,
  output logic          hit,
  output logic [15:0]   data
);

  logic          valid_q, valid_d;
  logic [AW-1:0] tag_q, tag_d;
  logic [15:0]   data_q, data_d;

  always_comb begin
    valid_d = valid_q;
    tag_d   = tag_q;
    data_d  = data_q;
    if (wr) begin
      valid_d = wr_valid;
      tag_d   = wr_tag;
      data_d  = wr_data;
    end
    // An invalidate always beats a fill landing in the same cycle
    if (clr) valid_d = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= 1'b0;
      tag_q   <= '0;
      data_q  <= '0;
    end else begin
      valid_q <= valid_d;
      tag_q   <= tag_d;
      data_q  <= data_d;
    end
  end

  assign hit  = cs & valid_q & (tag_q == addr);
  assign data = data_q;

endmodule

// File: rtl/jtcontra_gfx_romfetch.sv
// gfx1/gfx2 ROM fetch front-end: per-client hold buffers, round-robin miss
// arbitration onto one SDRAM read port. Define JTCONTRA_ROMFETCH_STATS_EN for hit/miss counters.
module jtcontra_gfx_romfetch
  import jtcontra_romfetch_pkg::*;
#(
  parameter int unsigned   AW          = 18,
  parameter int unsigned   SW          = 22,
  parameter logic [SW-1:0] GFX1_OFFSET = SW'(GFX1_OFFSET_DEF),
  parameter logic [SW-1:0] GFX2_OFFSET = SW'(GFX2_OFFSET_DEF)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     flush,
  input  logic                     gfx1_cs,
  input  logic [AW-1:0]            gfx1_addr,
  output logic [15:0]              gfx1_data,
  output logic                     gfx1_ok,
  input  logic                     gfx2_cs,
  input  logic [AW-1:0]            gfx2_addr,
  output logic [15:0]              gfx2_data,
  output logic                     gfx2_ok,
  jtcontra_gfx_romfetch_if.master  sdram
`ifdef JTCONTRA_ROMFETCH_STATS_EN
  ,
  output logic [15:0]              stat_hit1,
  output logic [15:0]              stat_miss1,
  output logic [15:0]              stat_hit2,
  output logic [15:0]              stat_miss2
`endif
);

  state_t        state_q, state_d;
  logic          owner_q, owner_d;
  logic          last_q, last_d;
  logic          discard_q, discard_d;
  logic [AW-1:0] tag_pend_q, tag_pend_d;
  logic          req_q, req_d;
  logic [SW-1:0] addr_q, addr_d;

  logic [1:0]    hit, miss;
  logic          fill, fill_valid, wr1, wr2;

  jtcontra_romfetch_slot #(.AW(AW)) u_slot1 (
    .clk, .rst, .clr(flush), .cs(gfx1_cs), .addr(gfx1_addr),
    .wr(wr1), .wr_valid(fill_valid), .wr_tag(tag_pend_q), .wr_data(sdram.dout),
    .hit(hit[GFX1]), .data(gfx1_data)
  );

  jtcontra_romfetch_slot #(.AW(AW)) u_slot2 (
    .clk, .rst, .clr(flush), .cs(gfx2_cs), .addr(gfx2_addr),
    .wr(wr2), .wr_valid(fill_valid), .wr_tag(tag_pend_q), .wr_data(sdram.dout),
    .hit(hit[GFX2]), .data(gfx2_data)
  );

  assign miss[GFX1] = gfx1_cs & ~hit[GFX1];
  assign miss[GFX2] = gfx2_cs & ~hit[GFX2];
  assign gfx1_ok    = hit[GFX1];
  assign gfx2_ok    = hit[GFX2];
  assign sdram.req  = req_q;
  assign sdram.addr = addr_q;

  always_comb begin
    state_d    = state_q;
    owner_d    = owner_q;
    last_d     = last_q;
    tag_pend_d = tag_pend_q;
    req_d      = req_q;
    addr_d     = addr_q;
    fill       = 1'b0;
    case (state_q)
      IDLE: begin
        if (|miss) begin
          owner_d    = (&miss) ? ~last_q : miss[GFX2];
          tag_pend_d = (owner_d == GFX2) ? gfx2_addr : gfx1_addr;
          addr_d     = ((owner_d == GFX2) ? GFX2_OFFSET : GFX1_OFFSET) + SW'(tag_pend_d);
          req_d      = 1'b1;
          state_d    = REQ;
        end
      end
      REQ: begin
        if (sdram.ack) begin
          req_d = 1'b0;
          // Data may return alongside the ack; complete without visiting WAIT
          if (sdram.rdy) begin
            fill    = 1'b1;
            last_d  = owner_q;
            state_d = IDLE;
          end else begin
            state_d = WAIT;
          end
        end
      end
      WAIT: begin
        if (sdram.rdy) begin
          fill    = 1'b1;
          last_d  = owner_q;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    discard_d  = (state_d == IDLE) ? 1'b0 : (discard_q | (flush & (state_q != IDLE)));
    fill_valid = ~discard_q & ~flush;
    wr1        = fill & (owner_q == GFX1);
    wr2        = fill & (owner_q == GFX2);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      owner_q    <= GFX1;
      last_q     <= GFX1;
      discard_q  <= 1'b0;
      tag_pend_q <= '0;
      req_q      <= 1'b0;
      addr_q     <= '0;
    end else begin
      state_q    <= state_d;
      owner_q    <= owner_d;
      last_q     <= last_d;
      discard_q  <= discard_d;
      tag_pend_q <= tag_pend_d;
      req_q      <= req_d;
      addr_q     <= addr_d;
    end
  end

`ifdef JTCONTRA_ROMFETCH_STATS_EN
  logic [1:0][15:0] shit_q, shit_d, smiss_q, smiss_d;
  logic [1:0]       issue;

  always_comb begin
    issue       = '0;
    issue[GFX1] = (state_q == IDLE) & (|miss) & (owner_d == GFX1);
    issue[GFX2] = (state_q == IDLE) & (|miss) & (owner_d == GFX2);
    for (int unsigned i = 0; i < 2; i++) begin
      shit_d[i]  = sat_inc(shit_q[i], hit[i]);
      smiss_d[i] = sat_inc(smiss_q[i], issue[i]);
    end
    if (flush) begin
      shit_d  = '0;
      smiss_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      shit_q  <= '0;
      smiss_q <= '0;
    end else begin
      shit_q  <= shit_d;
      smiss_q <= smiss_d;
    end
  end

  assign stat_hit1  = shit_q[GFX1];
  assign stat_miss1 = smiss_q[GFX1];
  assign stat_hit2  = shit_q[GFX2];
  assign stat_miss2 = smiss_q[GFX2];
`endif

endmodule

// File: tb/tb_jtcontra_gfx_romfetch.sv
// Bench for jtcontra_gfx_romfetch: SDRAM responder, buffer/request reference
// model, directed scenarios and a randomized traffic phase.
module tb_jtcontra_gfx_romfetch;

  logic        clk = 1'b0;
  logic        rst, flush, cs1, cs2;
  logic [17:0] a1, a2;
  logic [15:0] d1, d2;
  logic        ok1, ok2;

  always #5 clk = ~clk;

  jtcontra_gfx_romfetch_if #(.SW(22)) sd ();

`ifdef JTCONTRA_ROMFETCH_STATS_EN
  logic [15:0] sh1, sm1, sh2, sm2;
`endif

  jtcontra_gfx_romfetch #(
    .AW(18), .SW(22), .GFX1_OFFSET(22'h00_0000), .GFX2_OFFSET(22'h04_0000)
  ) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .gfx1_cs(cs1), .gfx1_addr(a1), .gfx1_data(d1), .gfx1_ok(ok1),
    .gfx2_cs(cs2), .gfx2_addr(a2), .gfx2_data(d2), .gfx2_ok(ok2),
    .sdram(sd.master)
`ifdef JTCONTRA_ROMFETCH_STATS_EN
    , .stat_hit1(sh1), .stat_miss1(sm1), .stat_hit2(sh2), .stat_miss2(sm2)
`endif
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: buffer contents and the single outstanding fetch
  bit          m_valid [2];
  logic [17:0] m_tag   [2];
  logic [15:0] m_data  [2];
  bit          m_last, m_busy, m_acked, m_disc, m_own;
  logic [17:0] m_pend;
  logic [21:0] m_addr;
  logic [15:0] m_hit   [2];
  logic [15:0] m_miss  [2];

  // SDRAM responder
  int          r_phase = 0, r_cnt = 0, ack_dly = 0, rdy_dly = 0;
  logic [21:0] r_addr = '0;
  bit          late_rdy = 0;
  logic [21:0] issued [$];

  function automatic logic [15:0] mem(input logic [21:0] a);
    if (a == 22'h000123) return 16'hBEEF;
    return a[15:0] ^ {10'h1A5, a[21:16]};
  endfunction

  function automatic logic [15:0] sinc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  // One clock: drive SDRAM side, check outputs, advance model, cross the edge
  task automatic cyc();
    bit e1, e2, mis1, mis2;
    sd.ack = 1'b0;
    sd.rdy = 1'b0;
    if (late_rdy) begin
      sd.rdy   = 1'b1;
      late_rdy = 0;
    end else begin
      if (r_phase == 0 && sd.req) begin
        issued.push_back(sd.addr);
        r_addr  = sd.addr;
        r_cnt   = 0;
        r_phase = 1;
      end
      if (r_phase == 1) begin
        if (r_cnt >= ack_dly) begin
          sd.ack = 1'b1;
          r_cnt  = 0;
          if (rdy_dly == 0) begin
            sd.rdy  = 1'b1;
            r_phase = 0;
          end else r_phase = 2;
        end else r_cnt++;
      end else if (r_phase == 2) begin
        r_cnt++;
        if (r_cnt >= rdy_dly) begin
          sd.rdy  = 1'b1;
          r_phase = 0;
        end
      end
    end
    sd.dout = sd.rdy ? mem(r_addr) : 16'($urandom);
    #1;
    e1 = cs1 && m_valid[0] && (m_tag[0] == a1);
    e2 = cs2 && m_valid[1] && (m_tag[1] == a2);
    check("ok1", 32'(ok1), 32'(e1));
    check("ok2", 32'(ok2), 32'(e2));
    if (e1) check("data1", 32'(d1), 32'(m_data[0]));
    if (e2) check("data2", 32'(d2), 32'(m_data[1]));
    check("req", 32'(sd.req), 32'(m_busy && !m_acked));
    if (m_busy && !m_acked) check("addr", 32'(sd.addr), 32'(m_addr));
`ifdef JTCONTRA_ROMFETCH_STATS_EN
    check("stat_hit1", 32'(sh1), 32'(m_hit[0]));
    check("stat_miss1", 32'(sm1), 32'(m_miss[0]));
    check("stat_hit2", 32'(sh2), 32'(m_hit[1]));
    check("stat_miss2", 32'(sm2), 32'(m_miss[1]));
`endif
    if (rst) begin
      m_valid = '{0, 0};  m_tag  = '{0, 0};  m_data = '{0, 0};
      m_hit   = '{0, 0};  m_miss = '{0, 0};
      m_busy = 0; m_acked = 0; m_disc = 0; m_last = 0;
    end else begin
      mis1 = cs1 && !e1;
      mis2 = cs2 && !e2;
      if (e1) m_hit[0] = sinc(m_hit[0]);
      if (e2) m_hit[1] = sinc(m_hit[1]);
      if (m_busy) begin
        if (flush) m_disc = 1;
        if (sd.ack) m_acked = 1;
        if (m_acked && sd.rdy) begin
          if (!m_disc) begin
            m_valid[m_own] = 1;
            m_tag[m_own]   = m_pend;
            m_data[m_own]  = sd.dout;
          end
          m_last = m_own;
          m_busy = 0;
        end
      end else if (mis1 || mis2) begin
        m_own  = (mis1 && mis2) ? !m_last : mis2;
        m_pend = m_own ? a2 : a1;
        m_addr = (m_own ? 22'h040000 : 22'h000000) + 22'(m_pend);
        m_busy = 1; m_acked = 0; m_disc = 0;
        m_miss[m_own] = sinc(m_miss[m_own]);
      end
      if (flush) begin
        m_valid = '{0, 0};
        m_hit   = '{0, 0};
        m_miss  = '{0, 0};
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic wait_idle(input string tag);
    int n = 0;
    cyc();
    while (m_busy && n < 200) begin
      cyc();
      n++;
    end
    check({tag, "_timeout"}, 32'(m_busy), 32'd0);
  endtask

  task automatic wait_wait(input string tag);
    int n = 0;
    while (r_phase != 2 && n < 200) begin
      cyc();
      n++;
    end
    check({tag, "_timeout"}, 32'(r_phase), 32'd2);
  endtask

  initial begin
    rst = 1'b1; flush = 1'b0; cs1 = 1'b0; cs2 = 1'b0; a1 = '0; a2 = '0;
    sd.ack = 1'b0; sd.rdy = 1'b0; sd.dout = '0;
    @(posedge clk); #1;
    repeat (3) cyc();
    check("rst_addr", 32'(sd.addr), 32'd0);
    check("rst_data1", 32'(d1), 32'd0);
    check("rst_data2", 32'(d2), 32'd0);
    rst = 1'b0;

    // Single miss then zero-latency hits
    issued.delete();
    ack_dly = 2; rdy_dly = 4; cs1 = 1'b1; a1 = 18'h00123;
    wait_idle("s1");
    check("s1_ok", 32'(ok1), 32'd1);
    check("s1_data", 32'(d1), 32'hBEEF);
    check("s1_sdaddr", 32'(issued[0]), 32'h000123);
    cs1 = 1'b0; cyc();
    cs1 = 1'b1; repeat (4) cyc();
    check("s1_noreq", 32'(issued.size()), 32'd1);

    // Simultaneous misses, gfx1 served last
    issued.delete();
    ack_dly = 1; rdy_dly = 2; a1 = 18'h10; a2 = 18'h20; cs2 = 1'b1;
    wait_idle("s2a");
    wait_idle("s2b");
    check("s2_first", 32'(issued[0]), 32'h040020);
    check("s2_second", 32'(issued[1]), 32'h000010);
    check("s2_ok1", 32'(ok1), 32'd1);
    check("s2_ok2", 32'(ok2), 32'd1);

    // Address change while data is in flight
    issued.delete();
    cs2 = 1'b0; a1 = 18'h5; rdy_dly = 3;
    wait_wait("s3");
    a1 = 18'h6;
    wait_idle("s3a");
    check("s3_ok_stale", 32'(ok1), 32'd0);
    wait_idle("s3b");
    check("s3_first", 32'(issued[0]), 32'h000005);
    check("s3_second", 32'(issued[1]), 32'h000006);

    // Flush during WAIT discards the fill
    issued.delete();
    a1 = 18'h77;
    wait_wait("s4");
    flush = 1'b1; cyc(); flush = 1'b0;
    wait_idle("s4a");
    check("s4_ok_disc", 32'(ok1), 32'd0);
    wait_idle("s4b");
    check("s4_reissue", 32'(issued.size()), 32'd2);
    check("s4_addr", 32'(issued[1]), 32'h000077);

    // ack and rdy together
    issued.delete();
    a1 = 18'h99; ack_dly = 1; rdy_dly = 0;
    wait_idle("s5");
    cyc();
    check("s5_single", 32'(issued.size()), 32'd1);

    // Reset in WAIT, late rdy ignored
    issued.delete();
    a1 = 18'hAA; ack_dly = 0; rdy_dly = 10;
    wait_wait("s6");
    rst = 1'b1; cyc(); rst = 1'b0;
    r_phase = 0; cs1 = 1'b0;
    cyc();
    check("s6_req", 32'(sd.req), 32'd0);
    late_rdy = 1; cyc();
    cs1 = 1'b1; cyc();
    check("s6_ok", 32'(ok1), 32'd0);
    rdy_dly = 2;
    wait_idle("s6b");
    check("s6_reissue", 32'(issued.size()), 32'd2);

    // Randomized traffic
    for (int i = 0; i < 400; i++) begin
      if (r_phase == 0) begin
        ack_dly = $urandom_range(0, 2);
        rdy_dly = $urandom_range(0, 3);
      end
      cs1 = ($urandom_range(0, 3) != 0);
      cs2 = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 4) == 0) a1 = 18'($urandom_range(0, 3));
      if ($urandom_range(0, 4) == 0) a2 = 18'h3FFF0 + 18'($urandom_range(0, 3));
      flush = ($urandom_range(0, 39) == 0);
      cyc();
    end
    flush = 1'b0; cs1 = 1'b0; cs2 = 1'b0;
    wait_idle("drain");

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
